// File: rtl/light_modu_arb.sv
// Frame-level arbiter sharing the light-modulator AXI-Stream input between two sources.
// Grants whole frames, inserts an idle gap after each, checks length headers, and counts frames.
module light_modu_arb #(
    parameter int GAP_CYCLES = 10,
    parameter int DATA_W     = 32
) (
    input  logic              light_modu_clk,
    input  logic              arst_n,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s0_tvalid,
    input  logic              s0_tlast,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic              s1_tvalid,
    input  logic              s1_tlast,
    output logic              s1_tready,
    output logic [DATA_W-1:0] light_modu_tdata,
    output logic              light_modu_tvalid,
    output logic              light_modu_tlast,
    input  logic              light_modu_tready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              len_err,
    output logic [15:0]       frame_cnt0,
    output logic [15:0]       frame_cnt1
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_GAP} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        grant_reg, grant_next;
    logic [1:0]        last_grant_reg, last_grant_next;
    logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
    logic [15:0]       beat_cnt_reg, beat_cnt_next;
    logic [DATA_W-1:0] hdr_reg, hdr_next;
    logic              len_err_reg, len_err_next;

    logic [1:0]        src_tvalid, src_tlast, src_tready;
    logic              pass, hs, len_ok;
    logic [15:0]       final_cnt;
    logic [DATA_W-1:0] hdr_eff;

    assign src_tvalid = {s1_tvalid, s0_tvalid};
    assign src_tlast  = {s1_tlast, s0_tlast};
    assign pass       = (state_reg == S_PASS);

    // Per-source pass-through gating and frame counters
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [DATA_W-1:0] tdata_in;
            logic [DATA_W-1:0] tdata_m;
            logic [15:0]       cnt_reg;

            assign tdata_in       = (gi == 0) ? s0_tdata : s1_tdata;
            assign tdata_m        = tdata_in & {DATA_W{pass && grant_reg[gi]}};
            assign src_tready[gi] = pass && grant_reg[gi] && light_modu_tready;

            always_ff @(posedge light_modu_clk or negedge arst_n) begin
                if (!arst_n)
                    cnt_reg <= '0;
                else if (hs && light_modu_tlast && grant_reg[gi])
                    cnt_reg <= cnt_reg + 16'd1;
            end
        end
    endgenerate

    assign light_modu_tdata  = g_src[0].tdata_m | g_src[1].tdata_m;
    assign light_modu_tvalid = pass && |(src_tvalid & grant_reg);
    assign light_modu_tlast  = pass && |(src_tlast & grant_reg);
    assign s0_tready         = src_tready[0];
    assign s1_tready         = src_tready[1];
    assign hs                = light_modu_tvalid && light_modu_tready;

    // A single-beat frame has no latched header yet, so compare against the live word
    assign final_cnt = (beat_cnt_reg == 16'hFFFF) ? 16'hFFFF : beat_cnt_reg + 16'd1;
    assign hdr_eff   = (beat_cnt_reg == 16'd0) ? light_modu_tdata : hdr_reg;
    assign len_ok    = (hdr_eff[DATA_W-1:18] == '0) &&
                       (hdr_eff[17:0] == {final_cnt, 2'b00}) &&
                       (final_cnt != 16'hFFFF);

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        gap_cnt_next    = gap_cnt_reg;
        beat_cnt_next   = beat_cnt_reg;
        hdr_next        = hdr_reg;
        len_err_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (|src_tvalid) begin
                    state_next    = S_PASS;
                    beat_cnt_next = '0;
                    grant_next    = (src_tvalid == 2'b11) ? ~last_grant_reg : src_tvalid;
                end
            end
            S_PASS: begin
                if (hs) begin
                    if (beat_cnt_reg != 16'hFFFF)
                        beat_cnt_next = beat_cnt_reg + 16'd1;
                    if (beat_cnt_reg == 16'd0)
                        hdr_next = light_modu_tdata;
                    if (light_modu_tlast) begin
                        len_err_next    = !len_ok;
                        last_grant_next = grant_reg;
                        grant_next      = '0;
                        gap_cnt_next    = '0;
                        state_next      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
                    state_next   = S_IDLE;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // last_grant resets to s1 so s0 wins the first tie
    always_ff @(posedge light_modu_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg      <= S_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= 2'b10;
            gap_cnt_reg    <= '0;
            beat_cnt_reg   <= '0;
            hdr_reg        <= '0;
            len_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            gap_cnt_reg    <= gap_cnt_next;
            beat_cnt_reg   <= beat_cnt_next;
            hdr_reg        <= hdr_next;
            len_err_reg    <= len_err_next;
        end
    end

    assign grant      = grant_reg;
    assign busy       = (state_reg == S_PASS) || (state_reg == S_GAP);
    assign len_err    = len_err_reg;
    assign frame_cnt0 = g_src[0].cnt_reg;
    assign frame_cnt1 = g_src[1].cnt_reg;

endmodule

// File: tb/tb_light_modu_arb.sv
// Directed bench for light_modu_arb: table of single-frame cases plus hand-written
// reset, contention and zero-gap sequences.
module tb_light_modu_arb;
    localparam int DW  = 32;
    localparam int GAP = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arst_n;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic          s0_tvalid, s0_tlast, s0_tready;
    logic          s1_tvalid, s1_tlast, s1_tready;
    logic          m_tvalid, m_tlast, m_tready;
    logic [1:0]    grant;
    logic          busy, len_err;
    logic [15:0]   fc0, fc1;

    light_modu_arb #(.GAP_CYCLES(GAP), .DATA_W(DW)) dut (
        .light_modu_clk(clk), .arst_n(arst_n),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .light_modu_tdata(m_tdata), .light_modu_tvalid(m_tvalid), .light_modu_tlast(m_tlast),
        .light_modu_tready(m_tready), .grant(grant), .busy(busy), .len_err(len_err),
        .frame_cnt0(fc0), .frame_cnt1(fc1)
    );

    // Zero-gap build
    logic [DW-1:0] z_s0_tdata, z_s1_tdata, z_m_tdata;
    logic          z_s0_tvalid, z_s0_tlast, z_s0_tready;
    logic          z_s1_tvalid, z_s1_tlast, z_s1_tready;
    logic          z_m_tvalid, z_m_tlast, z_m_tready;
    logic [1:0]    z_grant;
    logic          z_busy, z_len_err;
    logic [15:0]   z_fc0, z_fc1;

    light_modu_arb #(.GAP_CYCLES(0), .DATA_W(DW)) dut_z (
        .light_modu_clk(clk), .arst_n(arst_n),
        .s0_tdata(z_s0_tdata), .s0_tvalid(z_s0_tvalid), .s0_tlast(z_s0_tlast), .s0_tready(z_s0_tready),
        .s1_tdata(z_s1_tdata), .s1_tvalid(z_s1_tvalid), .s1_tlast(z_s1_tlast), .s1_tready(z_s1_tready),
        .light_modu_tdata(z_m_tdata), .light_modu_tvalid(z_m_tvalid), .light_modu_tlast(z_m_tlast),
        .light_modu_tready(z_m_tready), .grant(z_grant), .busy(z_busy), .len_err(z_len_err),
        .frame_cnt0(z_fc0), .frame_cnt1(z_fc1)
    );

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int          src;
        int          beats;
        logic [31:0] hdr;
        bit          rnd;
        int          exp_err;
    } vec_t;

    beat_t q0[$], q1[$], rx[$], expq[$];
    int    ptr0, ptr1;
    bit    rnd_ready;
    int    checks, errors, cyc;
    int    lenerr_seen, lenerr_cyc, bad_ready, gap_run;
    int    gap_lens[$], grant_order[$], last_cyc[$], grant_cyc[$];
    logic [1:0] prev_grant, g_s;
    logic       b_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        if (ptr0 < q0.size()) begin
            s0_tvalid = 1'b1; s0_tdata = q0[ptr0].data; s0_tlast = q0[ptr0].last;
        end else begin
            s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
        end
        if (ptr1 < q1.size()) begin
            s1_tvalid = 1'b1; s1_tdata = q1[ptr1].data; s1_tlast = q1[ptr1].last;
        end else begin
            s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
        end
    endtask

    task automatic cycle();
        bit h0, h1;
        @(negedge clk);
        cyc++;
        h0 = s0_tvalid && s0_tready;
        h1 = s1_tvalid && s1_tready;
        g_s = grant;
        b_s = busy;
        if (m_tvalid && m_tready) begin
            rx.push_back({m_tlast, m_tdata});
            if (m_tlast) last_cyc.push_back(cyc);
        end
        if (len_err) begin
            lenerr_seen++;
            lenerr_cyc = cyc;
        end
        if ((s0_tready && !grant[0]) || (s1_tready && !grant[1])) bad_ready++;
        if (grant != 2'b00 && prev_grant == 2'b00) begin
            grant_order.push_back(int'(grant));
            grant_cyc.push_back(cyc);
        end
        prev_grant = grant;
        if (busy && grant == 2'b00) gap_run++;
        else if (gap_run != 0) begin
            gap_lens.push_back(gap_run);
            gap_run = 0;
        end
        @(posedge clk);
        #1;
        if (h0) ptr0++;
        if (h1) ptr1++;
        m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        drive();
    endtask

    task automatic clear_all();
        q0.delete(); q1.delete(); rx.delete(); expq.delete();
        gap_lens.delete(); grant_order.delete(); last_cyc.delete(); grant_cyc.delete();
        ptr0 = 0; ptr1 = 0;
        lenerr_seen = 0; lenerr_cyc = -1; bad_ready = 0; gap_run = 0;
        prev_grant = 2'b00;
    endtask

    task automatic load(input int src, input int beats, input logic [31:0] hdr, input int tag);
        for (int k = 0; k < beats; k++) begin
            beat_t b;
            b.last = (k == beats - 1);
            b.data = (k == 0) ? hdr : {4'hA, 4'(src), 8'(tag), 16'(k)};
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
            expq.push_back(b);
        end
    endtask

    task automatic check_stream(input string name);
        int bad;
        bad = 0;
        chk({name, "_len"}, rx.size(), expq.size());
        for (int k = 0; k < rx.size() && k < expq.size(); k++)
            if (rx[k] !== expq[k]) bad++;
        chk({name, "_data"}, bad, 0);
    endtask

    task automatic wait_lasts(input int n, input string name);
        int budget;
        budget = 2000;
        while (last_cyc.size() < n && budget > 0) begin
            cycle();
            budget--;
        end
        chk({name, "_timeout"}, (budget == 0), 0);
    endtask

    vec_t vt[7];

    initial begin
        logic [15:0] fb0, fb1;
        int budget;
        checks = 0; errors = 0; cyc = 0;
        vt[0] = '{0, 40, 32'd160,     1'b0, 0};
        vt[1] = '{1, 12, 32'd48,      1'b1, 0};
        vt[2] = '{0,  5, 32'd16,      1'b0, 1};
        vt[3] = '{0,  1, 32'd4,       1'b0, 0};
        vt[4] = '{1,  1, 32'd8,       1'b0, 1};
        vt[5] = '{1,  3, 32'h0004000C, 1'b0, 1};
        vt[6] = '{0,  6, 32'd24,      1'b1, 0};

        clear_all();
        rnd_ready = 1'b0; m_tready = 1'b1;
        z_s0_tvalid = 1'b0; z_s0_tdata = '0; z_s0_tlast = 1'b0;
        z_s1_tvalid = 1'b0; z_s1_tdata = '0; z_s1_tlast = 1'b0;
        z_m_tready = 1'b1;
        drive();
        arst_n = 1'b0;
        #17;
        chk("rst_grant", grant, 0);
        chk("rst_flags", {busy, len_err, m_tvalid, m_tlast, s0_tready, s1_tready}, 0);
        chk("rst_cnts", {fc0, fc1}, 0);
        chk("rst_tdata", m_tdata, 0);
        #6 arst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            clear_all();
            rnd_ready = vt[i].rnd;
            fb0 = fc0; fb1 = fc1;
            load(vt[i].src, vt[i].beats, vt[i].hdr, i);
            drive();
            cycle();
            chk("idle_grant", g_s, 0);
            cycle();
            chk("grant", g_s, (vt[i].src == 0) ? 2'b01 : 2'b10);
            wait_lasts(1, "frame");
            repeat (GAP + 3) cycle();
            rnd_ready = 1'b0;
            check_stream("stream");
            chk("len_err_cnt", lenerr_seen, vt[i].exp_err);
            if (vt[i].exp_err != 0 && last_cyc.size() > 0)
                chk("len_err_time", lenerr_cyc, last_cyc[0] + 1);
            chk("frame_cnt", {fc0, fc1}, {fb0 + 16'(vt[i].src == 0), fb1 + 16'(vt[i].src == 1)});
            chk("gap_len", (gap_lens.size() == 1) ? gap_lens[0] : -1, GAP);
            chk("end_idle", b_s, 0);
            chk("bad_ready", bad_ready, 0);
            $display("vec %0d src %0d beats %0d hdr %0h len_err %0d fc0 %0d fc1 %0d",
                     i, vt[i].src, vt[i].beats, vt[i].hdr, lenerr_seen, fc0, fc1);
        end

        // Reset in the middle of a 40-beat frame
        clear_all();
        load(0, 40, 32'd160, 8);
        drive();
        budget = 200;
        while (ptr0 < 7 && budget > 0) begin
            cycle();
            budget--;
        end
        chk("mid_rst_timeout", (budget == 0), 0);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {grant, busy, len_err, m_tvalid, m_tlast, s0_tready, s1_tready}, 0);
        chk("mid_rst_tdata", m_tdata, 0);
        chk("mid_rst_fc0", fc0, 0);
        $display("reset after beat %0d fc0 %0d", ptr0, fc0);
        clear_all();
        drive();
        @(negedge clk); #2;
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Contention: both sources always valid, strict alternation starting with s0
        load(0, 3, 32'd12, 20);
        load(1, 3, 32'd12, 21);
        load(0, 3, 32'd12, 22);
        load(1, 3, 32'd12, 23);
        drive();
        wait_lasts(4, "contend");
        repeat (GAP + 3) cycle();
        chk("cont_grants", grant_order.size(), 4);
        for (int k = 0; k < grant_order.size() && k < 4; k++) begin
            chk("cont_order", grant_order[k], (k % 2 == 0) ? 1 : 2);
            $display("contention frame %0d grant %0d at cycle %0d", k, grant_order[k], grant_cyc[k]);
        end
        for (int k = 0; k < 3 && k + 1 < grant_cyc.size() && k < last_cyc.size(); k++)
            chk("cont_spacing", grant_cyc[k + 1] - last_cyc[k], GAP + 2);
        check_stream("cont_stream");
        chk("cont_bad_ready", bad_ready, 0);
        chk("cont_fc", {fc0, fc1}, {16'd2, 16'd2});
        chk("cont_len_err", lenerr_seen, 0);
        for (int k = 0; k < gap_lens.size(); k++)
            chk("cont_gap", gap_lens[k], GAP);

        // Zero-gap build: back-to-back s0 frames with one idle cycle between them
        @(posedge clk); #1;
        z_s0_tvalid = 1'b1; z_s0_tdata = 32'd8; z_s0_tlast = 1'b0;
        @(negedge clk);
        chk("z_idle_grant", z_grant, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_grant", z_grant, 2'b01);
        chk("z_hdr", {z_m_tvalid, z_m_tdata}, {1'b1, 32'd8});
        @(posedge clk); #1;
        z_s0_tdata = 32'h5555_0001; z_s0_tlast = 1'b1;
        @(negedge clk);
        chk("z_last", {z_m_tvalid, z_m_tlast, z_s0_tready}, 3'b111);
        @(posedge clk); #1;
        z_s0_tdata = 32'd4; z_s0_tlast = 1'b1;
        @(negedge clk);
        chk("z_idle_gap", {z_grant, z_busy, z_s0_tready, z_m_tvalid}, 0);
        chk("z_fc_a", z_fc0, 1);
        chk("z_len_ok_a", z_len_err, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_regrant", z_grant, 2'b01);
        chk("z_single", {z_m_tvalid, z_m_tlast, z_m_tdata}, {2'b11, 32'd4});
        @(posedge clk); #1;
        z_s0_tvalid = 1'b0; z_s0_tdata = '0; z_s0_tlast = 1'b0;
        @(negedge clk);
        chk("z_fc_b", z_fc0, 2);
        chk("z_len_ok_b", z_len_err, 0);
        chk("z_end", {z_grant, z_busy}, 0);
        $display("zero-gap frames fc0 %0d", z_fc0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
